// File: rtl/si_bullet_pkg.sv
// Shared definitions for the player-bullet sequencing logic.
// Row/step defaults are also used by the alien and collision blocks.
package si_bullet_pkg;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      IDLE   = 3'd1,
      LOAD   = 3'd2,
      FLY    = 3'd3,
      RETIRE = 3'd4
   } bulletState_t;

   localparam int unsigned BULLET_ROWS       = 8;
   localparam int unsigned BULLET_STEP_TICKS = 4;

endpackage

// File: rtl/si_bullet_step_counter.sv
// Game-tick divider: emits a one-cycle step on every STEP_TICKS-th enabled tick.
module si_bullet_step_counter
   import si_bullet_pkg::*;
#(
   parameter int unsigned STEP_TICKS = BULLET_STEP_TICKS,
   parameter int unsigned CNT_W      = 2
) (
   input  logic SC_StepCNT_CLOCK_50,
   input  logic SC_StepCNT_clear_InHigh,
   input  logic SC_StepCNT_enable_InHigh,
   input  logic SC_StepCNT_tick_InHigh,
   output logic SC_StepCNT_step_OutHigh
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STEP_TICKS - 1);

   logic [CNT_W-1:0] tickCount;
   logic             tickSeen;

   assign tickSeen = SC_StepCNT_enable_InHigh && SC_StepCNT_tick_InHigh;

   always_ff @(posedge SC_StepCNT_CLOCK_50) begin
      if (SC_StepCNT_clear_InHigh) begin
         tickCount <= '0;
      end else if (tickSeen) begin
         tickCount <= (tickCount == LAST_COUNT) ? '0 : tickCount + CNT_W'(1);
      end
   end

   // Step is combinational so the FSM acts on the same edge the wrapping tick arrives.
   assign SC_StepCNT_step_OutHigh = tickSeen && (tickCount == LAST_COUNT);

endmodule

// File: rtl/si_bullet_controller.sv
// Player-bullet sequencer: loads the player's column into the bullet shift
// register, advances it one row per step, and retires it on hit or escape.
module si_bullet_controller
   import si_bullet_pkg::*;
#(
   parameter int unsigned DATAWIDTH  = 8,
   parameter int unsigned ROWS       = BULLET_ROWS,
   parameter int unsigned ROW_W      = 3,
   parameter int unsigned STEP_TICKS = BULLET_STEP_TICKS,
   parameter int unsigned CNT_W      = 2
) (
   input  logic                 SC_BulletCTRL_CLOCK_50,
   input  logic                 SC_BulletCTRL_RESET_InHigh,
   input  logic                 SC_BulletCTRL_fire_InHigh,
   input  logic                 SC_BulletCTRL_tick_InHigh,
   input  logic                 SC_BulletCTRL_hit_InHigh,
   input  logic [DATAWIDTH-1:0] SC_BulletCTRL_playerCol_InBus,
   output logic                 SC_BulletCTRL_clear_OutLow,
   output logic                 SC_BulletCTRL_load_OutLow,
   output logic [DATAWIDTH-1:0] SC_BulletCTRL_data_OutBus,
   output logic [ROW_W-1:0]     SC_BulletCTRL_row_OutBus,
   output logic                 SC_BulletCTRL_active_OutHigh,
   output logic                 SC_BulletCTRL_done_OutHigh,
   output logic                 SC_BulletCTRL_hitFlag_OutHigh
);

   localparam logic [ROW_W-1:0] ROW_TOP = ROW_W'(ROWS - 1);

   bulletState_t           state;
   bulletState_t           stateNext;
   logic [ROW_W-1:0]       rowReg;
   logic [DATAWIDTH-1:0]   colReg;
   logic                   hitFlagReg;
   logic                   stepPulse;
   logic                   counterClear;

   assign counterClear = SC_BulletCTRL_RESET_InHigh || (state != FLY);

   si_bullet_step_counter #(
      .STEP_TICKS (STEP_TICKS),
      .CNT_W      (CNT_W)
   ) u_stepCounter (
      .SC_StepCNT_CLOCK_50      (SC_BulletCTRL_CLOCK_50),
      .SC_StepCNT_clear_InHigh  (counterClear),
      .SC_StepCNT_enable_InHigh (state == FLY),
      .SC_StepCNT_tick_InHigh   (SC_BulletCTRL_tick_InHigh),
      .SC_StepCNT_step_OutHigh  (stepPulse)
   );

   always_comb begin
      stateNext = state;
      case (state)
         INIT:   stateNext = IDLE;
         IDLE:   if (SC_BulletCTRL_fire_InHigh && (|SC_BulletCTRL_playerCol_InBus))
                    stateNext = LOAD;
         LOAD:   stateNext = FLY;
         FLY:    if (SC_BulletCTRL_hit_InHigh || (stepPulse && (rowReg == '0)))
                    stateNext = RETIRE;
         RETIRE: stateNext = IDLE;
         default: stateNext = INIT;
      endcase
   end

   always_ff @(posedge SC_BulletCTRL_CLOCK_50) begin
      if (SC_BulletCTRL_RESET_InHigh) begin
         state      <= INIT;
         rowReg     <= ROW_TOP;
         colReg     <= '0;
         hitFlagReg <= 1'b0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (stateNext == LOAD) begin
                  colReg     <= SC_BulletCTRL_playerCol_InBus;
                  rowReg     <= ROW_TOP;
                  hitFlagReg <= 1'b0;
               end
            end
            FLY: begin
               // Hit wins over a coincident step, so the row freezes where the hit landed.
               if (SC_BulletCTRL_hit_InHigh) begin
                  hitFlagReg <= 1'b1;
               end else if (stepPulse && (rowReg != '0)) begin
                  rowReg <= rowReg - ROW_W'(1);
               end
            end
            RETIRE: colReg <= '0;
            default: ;
         endcase
      end
   end

   assign SC_BulletCTRL_clear_OutLow    = !((state == INIT) || (state == RETIRE));
   assign SC_BulletCTRL_load_OutLow     = (state != LOAD);
   assign SC_BulletCTRL_data_OutBus     = colReg;
   assign SC_BulletCTRL_row_OutBus      = rowReg;
   assign SC_BulletCTRL_active_OutHigh  = (state == LOAD) || (state == FLY);
   assign SC_BulletCTRL_done_OutHigh    = (state == RETIRE);
   assign SC_BulletCTRL_hitFlag_OutHigh = hitFlagReg;

endmodule

// File: tb/tb_si_bullet_controller.sv
// Randomized bench for si_bullet_controller against a tick-count reference model.
module tb_si_bullet_controller;

   localparam int DW    = 8;
   localparam int ROWS  = 8;
   localparam int ROW_W = 3;
   localparam int ST    = 4;
   localparam int CNT_W = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            fire;
   logic            tick;
   logic            hit;
   logic [DW-1:0]   col;
   logic            clearN;
   logic            loadN;
   logic [DW-1:0]   data;
   logic [ROW_W-1:0] row;
   logic            active;
   logic            done;
   logic            hitFlag;

   always #10 clk = ~clk;

   si_bullet_controller #(
      .DATAWIDTH  (DW),
      .ROWS       (ROWS),
      .ROW_W      (ROW_W),
      .STEP_TICKS (ST),
      .CNT_W      (CNT_W)
   ) dut (
      .SC_BulletCTRL_CLOCK_50        (clk),
      .SC_BulletCTRL_RESET_InHigh    (rst),
      .SC_BulletCTRL_fire_InHigh     (fire),
      .SC_BulletCTRL_tick_InHigh     (tick),
      .SC_BulletCTRL_hit_InHigh      (hit),
      .SC_BulletCTRL_playerCol_InBus (col),
      .SC_BulletCTRL_clear_OutLow    (clearN),
      .SC_BulletCTRL_load_OutLow     (loadN),
      .SC_BulletCTRL_data_OutBus     (data),
      .SC_BulletCTRL_row_OutBus      (row),
      .SC_BulletCTRL_active_OutHigh  (active),
      .SC_BulletCTRL_done_OutHigh    (done),
      .SC_BulletCTRL_hitFlag_OutHigh (hitFlag)
   );

   int errCount   = 0;
   int checkCount = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: flight position is derived from the number of ticks since LOAD.
   bit mInit, mLoad, mFly, mRetire;
   int mCol, mHitFlag, mRowHeld, mTicks;

   function automatic int flightRow();
      return ROWS - 1 - mTicks / ST;
   endfunction

   function automatic bit modelIdle();
      return !(mInit || mLoad || mFly || mRetire);
   endfunction

   task automatic modelUpdate();
      if (rst) begin
         {mInit, mLoad, mFly, mRetire} = 4'b1000;
         mCol = 0; mHitFlag = 0; mRowHeld = ROWS - 1; mTicks = 0;
      end else if (mInit) begin
         mInit = 0;
      end else if (mLoad) begin
         mLoad = 0; mFly = 1;
      end else if (mFly) begin
         if (hit) begin
            mRowHeld = flightRow(); mHitFlag = 1; mFly = 0; mRetire = 1;
         end else if (tick) begin
            mTicks++;
            if (mTicks == ROWS * ST) begin
               mRowHeld = 0; mFly = 0; mRetire = 1;
            end
         end
      end else if (mRetire) begin
         mRetire = 0; mCol = 0;
      end else if (fire && col != 0) begin
         mLoad = 1; mCol = int'(col); mHitFlag = 0; mTicks = 0; mRowHeld = ROWS - 1;
      end
   endtask

   task automatic runCycle();
      int expRow;
      @(posedge clk);
      modelUpdate();
      #1;
      expRow = (mLoad || mFly) ? flightRow() : mRowHeld;
      checkVal("clearN",  32'(clearN),  32'(!(mInit || mRetire)));
      checkVal("loadN",   32'(loadN),   32'(!mLoad));
      checkVal("data",    32'(data),    32'(mCol));
      checkVal("row",     32'(row),     32'(expRow));
      checkVal("active",  32'(active),  32'(mLoad || mFly));
      checkVal("done",    32'(done),    32'(mRetire));
      checkVal("hitFlag", 32'(hitFlag), 32'(mHitFlag));
   endtask

   initial begin
      bit hitDone;
      rst = 1'b1; fire = 1'b0; tick = 1'b0; hit = 1'b0; col = '0;
      repeat (3) runCycle();
      rst = 1'b0;
      repeat (3) runCycle();

      // Single shot from column 4, continuous ticks until escape.
      col = 8'h10; fire = 1'b1;
      runCycle();
      fire = 1'b0; tick = 1'b1;
      for (int i = 0; i < 60 && !modelIdle(); i++) runCycle();
      repeat (2) runCycle();
      checkVal("escape_idle", 32'(modelIdle()), 32'd1);

      // Fire held high; first flight is hit at row 3 on a step tick.
      col = 8'h02; fire = 1'b1; hitDone = 0;
      for (int i = 0; i < 120; i++) begin
         hit = !hitDone && mFly && flightRow() == 3 && (mTicks % ST == ST - 1);
         if (hit) hitDone = 1;
         runCycle();
      end
      hit = 1'b0;
      checkVal("hit_seen", 32'(hitDone), 32'd1);

      // Empty column with fire never launches.
      fire = 1'b0;
      for (int i = 0; i < 60 && !modelIdle(); i++) runCycle();
      col = '0; fire = 1'b1;
      repeat (8) runCycle();

      // Reset mid-flight at row 4.
      col = 8'h80;
      runCycle();
      fire = 1'b0;
      for (int i = 0; i < 40 && !(mFly && flightRow() == 4); i++) runCycle();
      rst = 1'b1;
      runCycle();
      rst = 1'b0;
      repeat (2) runCycle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 399) == 0);
         fire = ($urandom_range(0, 3) == 0);
         tick = ($urandom_range(0, 1) == 1);
         hit  = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 5))
            0:       col = '0;
            1:       col = DW'($urandom);
            default: col = DW'(1) << $urandom_range(0, DW - 1);
         endcase
         runCycle();
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/si_bullet_controller.md
Name: si_bullet_controller

Overview:
- Sequencing FSM for the player-bullet shift register, which has active-low clear and load plus a data bus.
- Accepts a fire request and loads the player's one-hot column into the register.
- Advances the bullet one row every STEP_TICKS game ticks, then retires it on a hit or on escape past the top row.
- Sits between the player/collision logic and the bullet register; its row output feeds the display/collision matcher.

Parameters:
- DATAWIDTH, 8, column count; width of the bullet column vector.
- ROWS, 8, playfield rows; bullet starts at row ROWS-1 and escapes after row 0.
- ROW_W, 3, row index width (≥ clog2(ROWS)).
- STEP_TICKS, 4, game ticks per one-row advance (≥1).
- CNT_W, 2, tick counter width (≥ clog2(STEP_TICKS)).

Ports:
- SC_BulletCTRL_CLOCK_50  in  1  system clock (50 MHz).
- SC_BulletCTRL_RESET_InHigh  in  1  synchronous reset, active-high.
- SC_BulletCTRL_fire_InHigh  in  1  fire request; level sampled each cycle.
- SC_BulletCTRL_tick_InHigh  in  1  one-cycle game time-base strobe.
- SC_BulletCTRL_hit_InHigh  in  1  collision detected for the current bullet.
- SC_BulletCTRL_playerCol_InBus  in  DATAWIDTH  player column, one-hot.
- SC_BulletCTRL_clear_OutLow  out  1  to register clear (active-low).
- SC_BulletCTRL_load_OutLow  out  1  to register load (active-low).
- SC_BulletCTRL_data_OutBus  out  DATAWIDTH  to register data-in.
- SC_BulletCTRL_row_OutBus  out  ROW_W  current bullet row.
- SC_BulletCTRL_active_OutHigh  out  1  bullet in flight.
- SC_BulletCTRL_done_OutHigh  out  1  one-cycle pulse on retire.
- SC_BulletCTRL_hitFlag_OutHigh  out  1  last retire was a hit; held until next LOAD.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered or decoded from registered state only.
- States: INIT, IDLE, LOAD, FLY, RETIRE.
- Reset values (in reset and on the first cycle after release):
  - State = INIT.
  - clear_OutLow=0, load_OutLow=1.
  - data=0, row=ROWS-1, active=0, done=0, hitFlag=0.
  - Tick counter = 0.
- INIT: clear_OutLow=0 for exactly one cycle, done=0. Then IDLE unconditionally.
- IDLE: clear=1, load=1, active=0, data=0.
  - fire=1 and playerCol≠0 → LOAD; playerCol is captured as-is.
  - playerCol=0 → fire ignored.
- LOAD (1 cycle): load_OutLow=0, data=captured column, row=ROWS-1, active=1, hitFlag←0, tick counter←0. Then FLY.
  - Fire sampled in IDLE at cycle N gives load_OutLow=0 at N+1.
- FLY: load=1, clear=1, active=1; data holds the captured column.
  - On each tick: counter increments. When counter==STEP_TICKS-1 the tick is a step and the counter wraps to 0.
  - Step with row>0 → row decrements.
  - Step with row==0 → RETIRE (escape, hitFlag stays 0).
  - hit=1 → RETIRE with hitFlag←1.
  - hit has priority over a step in the same cycle.
  - hit is ignored outside FLY.
- RETIRE (1 cycle): clear_OutLow=0, done=1, active=0; data and row hold their values. Then IDLE.
- fire is ignored in LOAD, FLY and RETIRE; there is no queuing.
  - A fire held high from RETIRE is accepted on the first IDLE cycle.
  - Minimum fire-to-fire spacing is therefore LOAD + FLY + RETIRE + 1 IDLE cycle.
- tick is ignored outside FLY. A tick coincident with LOAD is not counted.
- Reset mid-flight → INIT on the next edge. This clears the shifter with no done pulse and drops hitFlag.
- Escape latency: ROWS×STEP_TICKS ticks after LOAD (32 with defaults).

Decomposition:
- Shared package si_bullet_pkg:
  - State encoding localparams: INIT, IDLE, LOAD, FLY, RETIRE.
  - Default ROWS / STEP_TICKS constants, shared with the alien/collision blocks.
- Sub-module si_bullet_step_counter:
  - Tick divider with inputs clear, enable, tick.
  - Produces the one-cycle step output; counter wraps at STEP_TICKS-1.
- FSM, row counter and output registers live in the top block.

Test Plan:
- Reset then release → clear_OutLow=0 for the release cycle plus the INIT cycle, then 1. All other outputs at reset values. done never pulses.
- playerCol=8'b0001_0000, fire pulse at cycle N → load_OutLow=0 and data=8'h10 at N+1, row=7, active=1. row=6 after the 4th tick following LOAD.
- No hit, continuous ticks → row steps 7→0, one step every 4 ticks. The 32nd tick gives RETIRE: clear_OutLow=0, done=1, hitFlag=0. Then IDLE.
- hit=1 at row=3, coincident with a step tick → row stays 3, RETIRE: done=1, hitFlag=1. hitFlag holds until the next LOAD.
- fire held high across a full flight → exactly one LOAD per flight. Second LOAD occurs one cycle after RETIRE. playerCol=0 with fire → no LOAD.
- Reset asserted during FLY at row=4 → next cycle INIT: clear_OutLow=0, active=0, done=0, row=7.
